// File: rtl/uart_tx_peripheral_if.sv
// CPU data-memory access bundle seen by the UART TX peripheral.
//   address     - byte address from the MEM stage
//   input_data  - store data (peripheral consumes [7:0])
//   mem_write   - store strobe
//   mem_read    - load strobe
//   output_data - load data returned by the peripheral
//   stall       - peripheral asks the MEM stage to hold the store
// master: CPU side, slave: peripheral side.
interface uart_tx_peripheral_if;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] output_data;
  logic        stall;

  modport master (
    output address, input_data, mem_write, mem_read,
    input  output_data, stall
  );

  modport slave (
    input  address, input_data, mem_write, mem_read,
    output output_data, stall
  );
endinterface

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped UART transmitter. Stores to TXDATA (+0x0) are queued in a
// small FIFO and serialised LSB first on tx. STATUS (+0x4) exposes
// {count[7:4], busy[2], empty[1], full[0]}. A store that finds the FIFO
// full raises stall so the MEM stage holds it.
// Optional feature macro: UART_TX_PARITY_EN adds an even parity bit (8E1);
// without it frames are 8N1.
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset
//   bus            - slave side of the data-memory access bundle
//   tx             - serial line, idle high
//   busy           - a frame is in progress
module uart_tx_peripheral #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h0000_1000,
  parameter int          CLOCK_DIVIDER = 117,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  uart_tx_peripheral_if.slave  bus,
  output logic                 tx,
  output logic                 busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLOCK_DIVIDER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state, state_n;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;
  logic            sel, wr_txdata, rd_status;
  logic [BW-1:0]   baud_cnt;
  logic            baud_end;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif
  logic            unused_data;

  assign unused_data = ^bus.input_data[31:8];

  // ---- bus decode ----
  assign sel       = (bus.address[31:4] == BASE_ADDRESS[31:4]);
  assign wr_txdata = sel && bus.mem_write && (bus.address[3:0] == 4'h0);
  assign rd_status = sel && bus.mem_read  && (bus.address[3:0] == 4'h4);

  // full/empty are from the registered count: a pop frees a slot for a
  // stalled store only on the following cycle.
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = wr_txdata && !full;
  assign bus.stall = wr_txdata && full;

  assign bus.output_data = rd_status ?
    {24'd0, 4'(count), 1'b0, busy, empty, full} : 32'd0;

  // ---- FIFO ----
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.input_data[7:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // ---- frame FSM ----
  assign baud_end = (baud_cnt == BW'(CLOCK_DIVIDER - 1));
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (baud_end) state_n = S_DATA;
      end
      S_DATA: begin
        tx = shift_reg[0];
        if (baud_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx = parity_q;
        if (baud_end) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (baud_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bit timing and shifter; a pop restarts the bit timer for the new frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (pop) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      parity_q  <= ^mem[rd_ptr];
`endif
    end else if (state != S_IDLE) begin
      baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
      if (state == S_DATA && baud_end) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + 3'd1;
      end
    end
  end
endmodule
